// File: rtl/cc_branch_unit.sv
// Condition-code register with a one-deep branch-resolve response slot and a
// saturating counter of taken branches handed to the consumer.
module cc_branch_unit #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_cc,
  input  logic [WIDTH-1:0]     cc_data,
  input  logic                 br_valid,
  input  logic [2:0]           br_nzp,
  output logic                 br_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_taken,
  input  logic                 cnt_clr,
  output logic [2:0]           cc_out,
  output logic [CNT_WIDTH-1:0] taken_count
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  localparam logic [2:0] CcN = 3'b100;
  localparam logic [2:0] CcZ = 3'b010;
  localparam logic [2:0] CcP = 3'b001;

  state_e               r_state;
  logic                 r_taken;
  logic [2:0]           r_cc;
  logic [CNT_WIDTH-1:0] r_count;

  logic [2:0] w_cc_class;
  logic       w_accept;
  logic       w_hit;
  logic       w_fire;
  logic       w_cnt_max;

  always_comb begin
    w_cc_class = CcP;
    if (cc_data[WIDTH-1]) begin
      w_cc_class = CcN;
    end else if (cc_data == '0) begin
      w_cc_class = CcZ;
    end
  end

  // A CC load stalls the request so it resolves against the updated CC next cycle.
  assign br_ready  = !rst && !load_cc && ((r_state == StEmpty) || resp_ready);
  assign w_accept  = br_valid && br_ready;
  assign w_hit     = |(r_cc & br_nzp);
  assign w_fire    = (r_state == StFull) && resp_ready && r_taken;
  assign w_cnt_max = (r_count == {CNT_WIDTH{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc <= CcZ;
    end else if (load_cc) begin
      r_cc <= w_cc_class;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StEmpty;
      r_taken <= 1'b0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_state <= StFull;
            r_taken <= w_hit;
          end
        end
        StFull: begin
          if (w_accept) begin
            r_taken <= w_hit;
          end else if (resp_ready) begin
            r_state <= StEmpty;
            r_taken <= 1'b0;
          end
        end
        default: begin
          r_state <= StEmpty;
          r_taken <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if (w_fire && !w_cnt_max) begin
      r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign resp_valid  = (r_state == StFull);
  assign resp_taken  = r_taken;
  assign cc_out      = r_cc;
  assign taken_count = r_count;

endmodule

// File: doc/cc_branch_unit.md
CC_BRANCH_UNIT -- requirements
Module: cc_branch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning width of the data word that sets the condition code.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning width of the taken-branch counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port load_cc, input, 1, meaning update the CC from cc_data this cycle.
REQ-006 SHALL have port cc_data, input, WIDTH, meaning the word classified into N/Z/P.
REQ-007 SHALL have port br_valid, input, 1, meaning a branch request is offered.
REQ-008 SHALL have port br_nzp, input, 3, meaning branch condition mask {n,z,p}.
REQ-009 SHALL have port br_ready, output, 1, meaning the request is accepted this cycle.
REQ-010 SHALL have port resp_valid, output, 1, meaning the resolved result is held.
REQ-011 SHALL have port resp_ready, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port resp_taken, output, 1, meaning branch taken, qualified by resp_valid.
REQ-013 SHALL have port cnt_clr, input, 1, meaning synchronous clear of the taken counter.
REQ-014 SHALL have ports cc_out, output, 3, the current {n,z,p}, and taken_count, output, CNT_WIDTH, the taken-branch count.

Function
REQ-015 SHALL hold a 3-bit one-hot CC register; on load_cc: n if cc_data[WIDTH-1]=1, else z if cc_data=0, else p.
REQ-016 SHALL keep CC unchanged when load_cc=0.
REQ-017 SHALL implement a two-state FSM: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-018 SHALL drive br_ready = !load_cc && (EMPTY || resp_ready), combinationally.
REQ-019 SHALL accept a request when br_valid && br_ready, and go to FULL at the next edge with resp_taken = |(cc_reg & br_nzp), using the CC value registered before that edge.
REQ-020 SHALL give latency of exactly 1 cycle from accept to resp_valid=1.
REQ-021 SHALL resolve br_nzp=3'b000 as not taken and 3'b111 as taken, independent of CC.
REQ-022 SHALL go FULL->EMPTY on resp_ready=1 with no accept in that cycle; on a simultaneous resp_ready and accept, stay FULL and load the new result (back-to-back, no bubble).
REQ-023 SHALL hold resp_taken stable while FULL and resp_ready=0.
REQ-024 SHALL, on a load_cc cycle, stall requests (br_ready=0); the request is accepted the following cycle against the updated CC.
REQ-025 SHALL increment taken_count by 1 when resp_valid && resp_ready && resp_taken.
REQ-026 SHALL saturate taken_count at all-ones with no wrap.
REQ-027 SHALL give cnt_clr priority over increment; the counter becomes 0 next edge.
REQ-028 SHALL keep resp_taken = 0 while EMPTY.

Reset
REQ-029 SHALL, on rst assertion, immediately and asynchronously set cc_out=3'b010 (Z), FSM=EMPTY (resp_valid=0, resp_taken=0) and taken_count=0.
REQ-030 SHALL drive br_ready=0 while rst=1.
REQ-031 SHALL discard a held or in-flight response on reset mid-operation, with no counter increment.
REQ-032 SHALL ignore load_cc and br_valid while rst=1.

Verification
REQ-033 SHALL cover the CC classification case: WIDTH=16, load_cc with cc_data 16'h8000, 16'h0000, 16'h0001 -> cc_out 100, 010, 001 on successive cycles.
REQ-034 SHALL cover the branch-resolve case: CC=001, request br_nzp=011 -> resp_valid=1 next cycle with resp_taken=1; br_nzp=110 -> resp_taken=0; 000 -> 0; 111 -> 1.
REQ-035 SHALL cover backpressure: resp_ready=0 for 3 cycles while FULL -> br_ready=0 and resp_taken stable; then resp_ready=1 with br_valid=1 -> a new result next cycle, no EMPTY cycle.
REQ-036 SHALL cover the hazard case: load_cc with 16'h0000 and br_valid in the same cycle -> br_ready=0; next cycle accepted, br_nzp=010 -> taken.
REQ-037 SHALL cover counter behaviour: CNT_WIDTH=2, 5 taken handshakes -> taken_count 1,2,3,3,3; cnt_clr with a taken handshake in the same cycle -> 0.
REQ-038 SHALL cover reset mid-operation: rst pulse while FULL with resp_taken=1 -> resp_valid=0, cc_out=010, taken_count=0 before the next clk edge.
